simmem_wresp_responder: RTL and testbench
=========================================

# simmem_wresp_responder

Memory-side responder for the simulated memory controller's write path. Accepts forwarded write-address requests, queues their IDs in arrival order, and returns one write response per request after a fixed configurable latency. It stands in for the real memory controller behind the simulated controller's write-response bank. Benches use it to close the write loop without external memory.

## Interface
Parameters:
- IDWidth, 4, width of AXI write ID
- QueueDepth, 8, number of outstanding requests held (power of two, ≥2)
- Latency, 5, cycles from AW handshake to earliest B valid (≥1)

Ports:
- clk_i  input  1  single clock; all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- write_addr_valid_i  input  1  AW request valid
- write_addr_ready_o  output  1  AW request ready
- write_addr_id_i  input  IDWidth  AW ID
- write_resp_valid_o  output  1  B response valid
- write_resp_ready_i  input  1  B response ready
- write_resp_id_o  output  IDWidth  B ID (equals AW ID of the oldest entry)
- write_resp_resp_o  output  2  B response code
- occupancy_o  output  $clog2(QueueDepth+1)  outstanding entries

## Operation
- Circular queue of QueueDepth entries {id, resp, countdown}; write pointer, read pointer, occupancy counter.
- Push on AW handshake (valid & ready): store id, resp = 2'b00, countdown = Latency.
- Every cycle, each occupied entry with countdown > 0 decrements by 1; saturates at 0. Countdown width $clog2(Latency+1).
- Head entry is presented: write_resp_valid_o = occupied & head countdown == 0. id/resp outputs driven from head entry.
- Pop on B handshake; read pointer advances and wraps modulo QueueDepth.
- Responses strictly in acceptance order; a later entry whose countdown reaches 0 waits behind the head.
- write_addr_ready_o = (occupancy != QueueDepth); depends on occupancy only, no same-cycle pop bypass.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Pointers wrap at QueueDepth-1 → 0.
- With empty queue, write_resp_id_o and write_resp_resp_o are held at 0.

## Timing
- Reset values: write_addr_ready_o=1, write_resp_valid_o=0, write_resp_id_o=0, write_resp_resp_o=0, occupancy_o=0; all entries invalid.
- AW handshake in cycle t → write_resp_valid_o high in cycle t+Latency if the entry is head; later otherwise.
- Once asserted, write_resp_valid_o and its id/resp stay stable until the handshake.
- Back-to-back AW every cycle yields back-to-back B every cycle when write_resp_ready_i=1.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation: all outstanding entries discarded immediately; no response is emitted for them after reset release.

## Configuration
- SIMMEM_WRESP_ERR_INJECT_EN: when defined, adds port err_inject_i (input, 1); an AW accepted while err_inject_i=1 stores resp = 2'b10 (SLVERR), otherwise 2'b00. When undefined, port is absent and write_resp_resp_o is constant 2'b00.

## Test plan
- Single AW id=3 at cycle 10, Latency=5, ready_i=1 → B valid cycle 15, id=3, resp=00, occupancy 1→0.
- 8 AWs ids 0..7, ready_i=0 → write_addr_ready_o=0 after 8th, occupancy=8; 9th AW stalls; ready_i=1 → B ids 0..7 in order, one per cycle.
- Full queue, AW valid and B handshake same cycle → AW not accepted that cycle, accepted next cycle; occupancy 8→7→8.
- AWs ids 5,9,2 on consecutive cycles, ready_i=1 → B ids 5,9,2 on consecutive cycles starting Latency cycles after first.
- 3 outstanding, rst_i pulsed one cycle → all outputs at reset values; no B for those IDs within 2×Latency cycles after release.
- With SIMMEM_WRESP_ERR_INJECT_EN: AW id=1 with err_inject_i=1, then id=2 with 0 → B id=1 resp=10, id=2 resp=00.

Source files
------------

// File: rtl/simmem_wresp_responder.sv
// simmem_wresp_responder
// Memory-side write responder. It accepts AW requests and queues their IDs in
// arrival order. It returns one B response per request, in acceptance order,
// no earlier than Latency cycles after the AW handshake.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   write_addr_valid_i/ready_o, write_addr_id_i        AW request channel
//   write_resp_valid_o/ready_i, write_resp_id_o/resp_o B response channel
//   occupancy_o               number of outstanding entries
//   err_inject_i              only with SIMMEM_WRESP_ERR_INJECT_EN defined:
//                             AW accepted while high is answered with SLVERR
//
// Optional feature macro: SIMMEM_WRESP_ERR_INJECT_EN. When it is undefined,
// write_resp_resp_o is the constant OKAY.
module simmem_wresp_responder #(
    parameter int unsigned IDWidth    = 4,
    parameter int unsigned QueueDepth = 8,
    parameter int unsigned Latency    = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              write_addr_valid_i,
    output logic                              write_addr_ready_o,
    input  logic [IDWidth-1:0]                write_addr_id_i,
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
    input  logic                              err_inject_i,
`endif
    output logic                              write_resp_valid_o,
    input  logic                              write_resp_ready_i,
    output logic [IDWidth-1:0]                write_resp_id_o,
    output logic [1:0]                        write_resp_resp_o,
    output logic [$clog2(QueueDepth+1)-1:0]   occupancy_o
);

    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = $clog2(Latency + 1);
    localparam int unsigned OccW = $clog2(QueueDepth + 1);

    // The acceptance cycle is already one cycle of latency, so the entry is
    // loaded with Latency-1. This puts B valid exactly Latency cycles after
    // the AW handshake.
    localparam logic [CntW-1:0] CntLoad = CntW'(Latency - 1);

    logic [QueueDepth-1:0] vld_q, vld_d;
    logic [IDWidth-1:0]    id_q  [QueueDepth];
    logic [IDWidth-1:0]    id_d  [QueueDepth];
    logic [CntW-1:0]       cnt_q [QueueDepth];
    logic [CntW-1:0]       cnt_d [QueueDepth];
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
    logic [1:0]            resp_q [QueueDepth];
    logic [1:0]            resp_d [QueueDepth];
`endif
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]       occ_q, occ_d;

    logic push;
    logic pop;
    logic head_ready;

    // Pointer increment with explicit wrap at QueueDepth-1.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(QueueDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Handshakes. Ready looks at occupancy only; a pop in the same cycle
    // does not free a slot for a push.
    always_comb begin
        write_addr_ready_o = (occ_q != OccW'(QueueDepth));
        head_ready         = vld_q[rd_ptr_q] && (cnt_q[rd_ptr_q] == '0);
        push               = write_addr_valid_i && write_addr_ready_o;
        pop                = head_ready && write_resp_ready_i;
    end

    // Next queue state: count down, then pop the head, then push the new entry.
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        resp_d   = resp_q;
`endif
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        for (int i = 0; i < int'(QueueDepth); i++) begin
            if (vld_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end

        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            id_d[wr_ptr_q]  = write_addr_id_i;
            cnt_d[wr_ptr_q] = CntLoad;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
            resp_d[wr_ptr_q] = err_inject_i ? 2'b10 : 2'b00;
`endif
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Queue state registers; reset discards every outstanding entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(QueueDepth); i++) begin
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
                resp_q[i] <= '0;
`endif
            end
        end else begin
            vld_q    <= vld_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
            resp_q   <= resp_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Head presentation. ID and code read as zero when the head slot is empty.
    always_comb begin
        write_resp_valid_o = head_ready;
        write_resp_id_o    = vld_q[rd_ptr_q] ? id_q[rd_ptr_q] : '0;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        write_resp_resp_o  = vld_q[rd_ptr_q] ? resp_q[rd_ptr_q] : 2'b00;
`else
        write_resp_resp_o  = 2'b00;
`endif
        occupancy_o        = occ_q;
    end

endmodule

// File: tb/tb_simmem_wresp_responder.sv
// Directed bench for simmem_wresp_responder (IDWidth=4, QueueDepth=8, Latency=5).
module tb_simmem_wresp_responder;

    localparam int unsigned IDW   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LAT   = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           awv = 1'b0;
    logic           awr;
    logic [IDW-1:0] awid = '0;
    logic           bv;
    logic           br = 1'b0;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic [3:0]     occ;
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
    logic           err = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    simmem_wresp_responder #(
        .IDWidth   (IDW),
        .QueueDepth(DEPTH),
        .Latency   (LAT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .write_addr_valid_i(awv),
        .write_addr_ready_o(awr),
        .write_addr_id_i   (awid),
`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        .err_inject_i      (err),
`endif
        .write_resp_valid_o(bv),
        .write_resp_ready_i(br),
        .write_resp_id_o   (bid),
        .write_resp_resp_o (bresp),
        .occupancy_o       (occ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push ids 0..7 on consecutive cycles; returns at the negedge after the last push.
    task automatic fill8();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            awv  = 1'b1;
            awid = IDW'(i);
        end
        @(negedge clk);
        awv = 1'b0;
    endtask

    // Hard stop in case the run wedges.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        int exp_id[6];
        int drain_ids[8];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(awr), 32'd1);
        check("rst_valid", 32'(bv), 32'd0);
        check("rst_id", 32'(bid), 32'd0);
        check("rst_resp", 32'(bresp), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single AW id=3: B valid exactly LAT cycles after the handshake
        br   = 1'b1;
        awv  = 1'b1;
        awid = 4'd3;
        @(negedge clk);
        awv = 1'b0;
        check("t1_occ1", 32'(occ), 32'd1);
        lat = 1;
        while (!bv && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_id", 32'(bid), 32'd3);
        check("t1_resp", 32'(bresp), 32'd0);
        @(negedge clk);
        check("t1_occ0", 32'(occ), 32'd0);
        check("t1_valid0", 32'(bv), 32'd0);

        // Fill with B stalled, 9th AW must stall, then drain in order
        br = 1'b0;
        fill8();
        check("t2_ready0", 32'(awr), 32'd0);
        check("t2_occ8", 32'(occ), 32'd8);
        awv  = 1'b1;
        awid = 4'd9;
        repeat (3) @(negedge clk);
        check("t2_stall_occ", 32'(occ), 32'd8);
        awv = 1'b0;
        repeat (4) @(negedge clk);
        br = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_bvalid", 32'(bv), 32'd1);
            check("t2_bid", 32'(bid), 32'(i));
            @(negedge clk);
        end
        check("t2_empty_valid", 32'(bv), 32'd0);
        check("t2_empty_occ", 32'(occ), 32'd0);
        check("t2_empty_id", 32'(bid), 32'd0);

        // Full queue with simultaneous AW and B: AW waits one cycle
        br = 1'b0;
        fill8();
        repeat (6) @(negedge clk);
        check("t3_head_valid", 32'(bv), 32'd1);
        check("t3_occ8", 32'(occ), 32'd8);
        awv  = 1'b1;
        awid = 4'd10;
        br   = 1'b1;
        @(negedge clk);
        check("t3_occ7", 32'(occ), 32'd7);
        check("t3_ready1", 32'(awr), 32'd1);
        br = 1'b0;
        @(negedge clk);
        check("t3_occ8_again", 32'(occ), 32'd8);
        awv = 1'b0;
        br  = 1'b1;
        drain_ids = '{1, 2, 3, 4, 5, 6, 7, 10};
        for (int i = 0; i < 8; i++) begin
            check("t3_bvalid", 32'(bv), 32'd1);
            check("t3_bid", 32'(bid), 32'(drain_ids[i]));
            @(negedge clk);
        end
        check("t3_occ0", 32'(occ), 32'd0);

        // Consecutive AWs 5,9,2: B on consecutive cycles from LAT after first
        br = 1'b1;
        @(negedge clk);
        awv  = 1'b1;
        awid = 4'd5;
        @(negedge clk);
        awid = 4'd9;
        @(negedge clk);
        awid = 4'd2;
        @(negedge clk);
        awv = 1'b0;
        exp_id = '{-1, -1, 5, 9, 2, -1};
        for (int j = 0; j < 6; j++) begin
            if (exp_id[j] < 0) begin
                check("t4_idle", 32'(bv), 32'd0);
            end else begin
                check("t4_bvalid", 32'(bv), 32'd1);
                check("t4_bid", 32'(bid), 32'(exp_id[j]));
            end
            @(negedge clk);
        end

        // Reset with 3 outstanding discards them
        br = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            awv  = 1'b1;
            awid = IDW'(i);
            @(negedge clk);
        end
        awv = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_pre_valid", 32'(bv), 32'd1);
        check("t5_pre_occ", 32'(occ), 32'd3);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bv), 32'd0);
        check("t5_rst_ready", 32'(awr), 32'd1);
        check("t5_rst_id", 32'(bid), 32'd0);
        check("t5_rst_occ", 32'(occ), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        br   = 1'b1;
        seen = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (bv) seen++;
        end
        check("t5_no_resp", 32'(seen), 32'd0);
        check("t5_occ", 32'(occ), 32'd0);

`ifdef SIMMEM_WRESP_ERR_INJECT_EN
        // Error injection: id 1 gets SLVERR, id 2 gets OKAY
        br   = 1'b0;
        awv  = 1'b1;
        awid = 4'd1;
        err  = 1'b1;
        @(negedge clk);
        awid = 4'd2;
        err  = 1'b0;
        @(negedge clk);
        awv = 1'b0;
        repeat (6) @(negedge clk);
        br = 1'b1;
        check("t6_id1", 32'(bid), 32'd1);
        check("t6_resp1", 32'(bresp), 32'd2);
        @(negedge clk);
        check("t6_id2", 32'(bid), 32'd2);
        check("t6_resp2", 32'(bresp), 32'd0);
        @(negedge clk);
        check("t6_empty", 32'(bv), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
